// File: rtl/set_time_multi.sv
// -----------------------------------------------------------------------------
// set_time_multi
//   Preset minutes:seconds store for a multi-player chess timer. The operator
//   steps the selected channel/field up or down with the add/sub buttons;
//   holding a button auto-repeats after REPEAT_DLY cycles, then every
//   REPEAT_RATE cycles. The packed outputs are the load values for the
//   countdown blocks.
//
// Ports
//   clk           system clock
//   rst_n         synchronous active-low reset
//   enable        setting mode; low suppresses steps and idles the repeat FSM
//   add, sub      debounced, clk-synchronous button levels
//   field         0 = minutes, 1 = seconds
//   sel           target channel index (out-of-range indices are ignored)
//   load_default  reload DEF_MIN:DEF_SEC into every channel
//   min, sec      packed 6-bit fields, channel i at [6i+5:6i]
//   is_zero       bit i high when channel i holds 0:00
// -----------------------------------------------------------------------------
module set_time_multi #(
    parameter int CHANNELS    = 2,
    parameter int MIN_MAX     = 59,
    parameter int DEF_MIN     = 5,
    parameter int DEF_SEC     = 0,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 10000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    add,
    input  logic                    sub,
    input  logic                    field,
    input  logic [2:0]              sel,
    input  logic                    load_default,
    output logic [6*CHANNELS-1:0]   min,
    output logic [6*CHANNELS-1:0]   sec,
    output logic [CHANNELS-1:0]     is_zero
);

    // Counter only ever holds values up to max(DLY, RATE) - 1.
    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [5:0]       MIN_TOP   = 6'(MIN_MAX);
    localparam logic [5:0]       SEC_TOP   = 6'd59;
    localparam logic [5:0]       DEF_MIN_V = 6'(DEF_MIN);
    localparam logic [5:0]       DEF_SEC_V = 6'(DEF_SEC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;   // 1 = add held, 0 = sub held
    logic             add_d, sub_d;
    logic             add_edge, sub_edge, one_btn;
    logic             step;

    // Wrapping +/-1 on a 6-bit field with an inclusive upper limit.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] top,
                                             input logic       up);
        if (up)
            return (v == top) ? 6'd0 : v + 6'd1;
        else
            return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    assign add_edge = add & ~add_d;
    assign sub_edge = sub & ~sub_d;
    assign one_btn  = add ^ sub;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            add_d     <= 1'b0;
            sub_d     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            add_d     <= add;
            sub_d     <= sub;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        step       = 1'b0;
        if (!enable || !one_btn) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (add_edge || sub_edge) begin
                        step       = 1'b1;
                        dir_next   = add;
                        cnt_next   = '0;
                        state_next = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    // A swap of buttons without an idle cycle counts as a release.
                    if (add != dir_reg) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == ((state_reg == HOLD) ? DLY_LAST : RATE_LAST)) begin
                        step       = 1'b1;
                        cnt_next   = '0;
                        state_next = REPEAT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // One preset register pair per channel; a step only ever hits the
    // channel matching sel, and exactly one button is high whenever step is
    // set, so add alone gives the direction.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [5:0] min_reg, sec_reg;
        logic       hit;

        assign hit = step && (sel == 3'(gi));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                min_reg <= DEF_MIN_V;
                sec_reg <= DEF_SEC_V;
            end else if (load_default) begin
                min_reg <= DEF_MIN_V;
                sec_reg <= DEF_SEC_V;
            end else if (hit) begin
                if (field)
                    sec_reg <= wrap_step(sec_reg, SEC_TOP, add);
                else
                    min_reg <= wrap_step(min_reg, MIN_TOP, add);
            end
        end

        assign min[6*gi +: 6] = min_reg;
        assign sec[6*gi +: 6] = sec_reg;
        assign is_zero[gi]    = (min_reg == 6'd0) && (sec_reg == 6'd0);
    end

endmodule

// File: tb/tb_set_time_multi.sv
// -----------------------------------------------------------------------------
// tb_set_time_multi
//   Directed scenarios followed by random button activity. Expected values
//   come from a reference model that tracks how long a button has been held
//   and derives step instants arithmetically from that hold age.
// -----------------------------------------------------------------------------
module tb_set_time_multi;

    localparam int CH   = 2;
    localparam int MMAX = 59;
    localparam int DMIN = 5;
    localparam int DSEC = 0;
    localparam int DLY  = 4;
    localparam int RATE = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             add = 1'b0;
    logic             sub = 1'b0;
    logic             field = 1'b0;
    logic [2:0]       sel = 3'd0;
    logic             load_default = 1'b0;
    logic [6*CH-1:0]  min, sec;
    logic [CH-1:0]    is_zero;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_min [CH];
    int m_sec [CH];
    bit prev_add, prev_sub;
    bit active, act_up;
    int age;

    set_time_multi #(
        .CHANNELS(CH), .MIN_MAX(MMAX), .DEF_MIN(DMIN), .DEF_SEC(DSEC),
        .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .add(add), .sub(sub),
        .field(field), .sel(sel), .load_default(load_default),
        .min(min), .sec(sec), .is_zero(is_zero)
    );

    always #5 clk = ~clk;

    task automatic model_defaults();
        for (int i = 0; i < CH; i++) begin
            m_min[i] = DMIN;
            m_sec[i] = DSEC;
        end
    endtask

    // Model of one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit do_step;
        bit up;
        do_step = 1'b0;
        up      = add;
        if (!rst_n) begin
            model_defaults();
            prev_add = 1'b0;
            prev_sub = 1'b0;
            active   = 1'b0;
            return;
        end
        if (!enable || (add == sub)) begin
            active = 1'b0;
        end else if (!active) begin
            if ((add && !prev_add) || (sub && !prev_sub)) begin
                active  = 1'b1;
                act_up  = up;
                age     = 0;
                do_step = 1'b1;
            end
        end else if (up != act_up) begin
            active = 1'b0;
        end else begin
            age++;
            if (age >= DLY && ((age - DLY) % RATE) == 0)
                do_step = 1'b1;
        end
        if (load_default) begin
            model_defaults();
        end else if (do_step && sel < CH) begin
            if (field)
                m_sec[sel] = up ? (m_sec[sel] + 1) % 60 : (m_sec[sel] + 59) % 60;
            else
                m_min[sel] = up ? (m_min[sel] + 1) % (MMAX + 1) : (m_min[sel] + MMAX) % (MMAX + 1);
        end
        prev_add = add;
        prev_sub = sub;
    endtask

    task automatic compare_all(input string tag);
        logic [6*CH-1:0] e_min, e_sec;
        logic [CH-1:0]   e_zero;
        for (int i = 0; i < CH; i++) begin
            e_min[6*i +: 6] = 6'(m_min[i]);
            e_sec[6*i +: 6] = 6'(m_sec[i]);
            e_zero[i]       = (m_min[i] == 0) && (m_sec[i] == 0);
        end
        checks++;
        assert (min === e_min) else begin
            errors++;
            $error("FAIL %s min observed=%h expected=%h", tag, min, e_min);
        end
        checks++;
        assert (sec === e_sec) else begin
            errors++;
            $error("FAIL %s sec observed=%h expected=%h", tag, sec, e_sec);
        end
        checks++;
        assert (is_zero === e_zero) else begin
            errors++;
            $error("FAIL %s is_zero observed=%b expected=%b", tag, is_zero, e_zero);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        $display("cyc rst_n=%0b en=%0b add=%0b sub=%0b fld=%0b sel=%0d ld=%0b min=%h sec=%h z=%b",
                 rst_n, enable, add, sub, field, sel, load_default, min, sec, is_zero);
    endtask

    task automatic pulse(input bit a, input bit s, input string tag);
        add = a;
        sub = s;
        cycle(tag);
        add = 1'b0;
        sub = 1'b0;
        cycle(tag);
    endtask

    // Checks against constants the scenario itself dictates.
    task automatic expect_ch(input int ch, input int m, input int s, input string tag);
        checks++;
        assert (min[6*ch +: 6] === 6'(m) && sec[6*ch +: 6] === 6'(s)) else begin
            errors++;
            $error("FAIL %s ch%0d observed=%0d:%0d expected=%0d:%0d",
                   tag, ch, min[6*ch +: 6], sec[6*ch +: 6], m, s);
        end
    endtask

    initial begin
        model_defaults();
        prev_add = 1'b0;
        prev_sub = 1'b0;
        active   = 1'b0;
        act_up   = 1'b0;
        age      = 0;

        // 1: reset state and a single add step
        rst_n = 1'b0;
        cycle("reset");
        cycle("reset");
        expect_ch(0, 5, 0, "reset_ch0");
        expect_ch(1, 5, 0, "reset_ch1");
        checks++;
        assert (is_zero === 2'b00) else begin
            errors++;
            $error("FAIL reset_zero observed=%b expected=%b", is_zero, 2'b00);
        end
        rst_n = 1'b1;
        cycle("idle");
        pulse(1'b1, 1'b0, "add1");
        expect_ch(0, 6, 0, "add1_ch0");
        expect_ch(1, 5, 0, "add1_ch1");

        // 2: minute wrap both ways, seconds borrow-free wrap
        for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1, "sub_to_59");
        expect_ch(0, 59, 0, "min59");
        pulse(1'b1, 1'b0, "wrap_up");
        expect_ch(0, 0, 0, "min_wrap_up");
        pulse(1'b0, 1'b1, "wrap_dn");
        expect_ch(0, 59, 0, "min_wrap_dn");
        field = 1'b1;
        pulse(1'b0, 1'b1, "sec_wrap");
        expect_ch(0, 59, 59, "sec_wrap_dn");
        field = 1'b0;

        // 3: auto-repeat, 12-cycle hold from 5:00
        load_default = 1'b1;
        cycle("load");
        load_default = 1'b0;
        add = 1'b1;
        for (int i = 0; i < 12; i++) cycle("hold12");
        add = 1'b0;
        cycle("release");
        expect_ch(0, 10, 0, "repeat_min10");

        // 4: both buttons, enable drop in REPEAT, re-enable while held
        pulse(1'b1, 1'b1, "both");
        expect_ch(0, 10, 0, "both_nochange");
        add = 1'b1;
        for (int i = 0; i < 7; i++) cycle("to_repeat");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cycle("disabled");
        enable = 1'b1;
        for (int i = 0; i < 8; i++) cycle("reenabled");
        expect_ch(0, 13, 0, "reenable_nostep");
        add = 1'b0;
        cycle("release");

        // 5: out-of-range sel, then drive ch1 to 0:00
        sel = 3'd3;
        pulse(1'b1, 1'b0, "sel3");
        expect_ch(0, 13, 0, "sel3_ch0");
        expect_ch(1, 5, 0, "sel3_ch1");
        sel = 3'd1;
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, "ch1_down");
        checks++;
        assert (is_zero === 2'b10) else begin
            errors++;
            $error("FAIL is_zero_ch1 observed=%b expected=%b", is_zero, 2'b10);
        end

        // 6: load_default beats a step; reset mid-HOLD
        sel = 3'd0;
        load_default = 1'b1;
        add = 1'b1;
        cycle("load_vs_add");
        load_default = 1'b0;
        add = 1'b0;
        cycle("load_vs_add");
        expect_ch(0, 5, 0, "load_ch0");
        expect_ch(1, 5, 0, "load_ch1");
        add = 1'b1;
        cycle("hold");
        cycle("hold");
        add = 1'b0;
        rst_n = 1'b0;
        cycle("rst_mid_hold");
        rst_n = 1'b1;
        cycle("after_rst");
        cycle("after_rst");
        expect_ch(0, 5, 0, "rst_hold_ch0");

        // Random activity against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8)       add = ~add;
            else if (r < 12) sub = ~sub;
            if ($urandom_range(0, 99) < 5) field = ~field;
            if ($urandom_range(0, 99) < 5) sel = 3'($urandom_range(0, 3));
            enable       = ($urandom_range(0, 99) >= 3);
            load_default = ($urandom_range(0, 99) < 2);
            rst_n        = ($urandom_range(0, 199) != 0);
            cycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
